// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: PS/2 keyboard frame receiver, E0/F0 prefix decoder and
// per-key held/released tracker, all in the system clock domain.
// Optional feature macro: PS2_PARITY_CHECK_EN (enables odd-parity checking).
module ps2_key_tracker #(
    parameter int unsigned                NUM_KEYS       = 4,
    parameter logic [NUM_KEYS*9-1:0]      KEYMAP         = {9'h023, 9'h01B, 9'h01C, 9'h01D},
    parameter int unsigned                SYNC_STAGES    = 2,
    parameter int unsigned                TIMEOUT_CYCLES = 50000
) (
    input  logic                Clock,
    input  logic                ResetN,
    input  logic                Ps2Clk,
    input  logic                Ps2Data,
    output logic [NUM_KEYS-1:0] KeyDown,
    output logic                ScanValid,
    output logic [7:0]          ScanCode,
    output logic                ScanBreak,
    output logic                ScanExt,
    output logic                FrameErr
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;

    state_t                 r_state;
    logic [2:0]             r_bitcnt;
    logic [7:0]             r_shift;
    logic [WD_W-1:0]        r_wdog;
    logic                   r_ext;
    logic                   r_brk;

    logic [NUM_KEYS-1:0]    r_keydown;
    logic                   r_scan_valid;
    logic [7:0]             r_scan_code;
    logic                   r_scan_break;
    logic                   r_scan_ext;
    logic                   r_frame_err;

    logic                   w_clk_s;
    logic                   w_data_s;
    logic                   w_fall;
    logic                   w_par_ok;
    logic                   w_frame_ok;

`ifdef PS2_PARITY_CHECK_EN
    logic                   r_parity;
`endif

    // Synchronisers for both pins, preset high (idle bus level)
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], Ps2Clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], Ps2Data};
            r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
        end
    end

    // Falling-edge detect and stop/parity qualification of the current frame
    always_comb begin
        w_clk_s  = r_clk_sync[SYNC_STAGES-1];
        w_data_s = r_data_sync[SYNC_STAGES-1];
        w_fall   = r_clk_prev & ~w_clk_s;
`ifdef PS2_PARITY_CHECK_EN
        w_par_ok = ^{r_shift, r_parity};
`else
        w_par_ok = 1'b1;
`endif
        w_frame_ok = w_data_s & w_par_ok;
    end

    // Frame FSM, watchdog, prefix decoder and key table with registered outputs
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_state      <= S_IDLE;
            r_bitcnt     <= '0;
            r_shift      <= '0;
            r_wdog       <= '0;
            r_ext        <= 1'b0;
            r_brk        <= 1'b0;
            r_keydown    <= '0;
            r_scan_valid <= 1'b0;
            r_scan_code  <= '0;
            r_scan_break <= 1'b0;
            r_scan_ext   <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            r_parity     <= 1'b0;
`endif
        end else begin
            r_scan_valid <= 1'b0;
            r_frame_err  <= 1'b0;

            if (w_fall || r_state == S_IDLE) begin
                r_wdog <= '0;
            end else if (r_wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                // Watchdog expiry: abandon the partial frame and any prefixes
                r_wdog      <= '0;
                r_state     <= S_IDLE;
                r_frame_err <= 1'b1;
                r_ext       <= 1'b0;
                r_brk       <= 1'b0;
            end else begin
                r_wdog <= r_wdog + 1'b1;
            end

            if (w_fall) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_data_s) begin
                            r_state  <= S_DATA;
                            r_bitcnt <= '0;
                        end
                    end
                    S_DATA: begin
                        r_shift <= {w_data_s, r_shift[7:1]};
                        if (r_bitcnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end else begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                        end
                    end
                    S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        r_parity <= w_data_s;
`endif
                        r_state  <= S_STOP;
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        if (!w_frame_ok) begin
                            r_frame_err <= 1'b1;
                            r_ext       <= 1'b0;
                            r_brk       <= 1'b0;
                        end else if (r_shift == 8'hE0) begin
                            r_ext <= 1'b1;
                        end else if (r_shift == 8'hF0) begin
                            r_brk <= 1'b1;
                        end else begin
                            r_scan_valid <= 1'b1;
                            r_scan_code  <= r_shift;
                            r_scan_break <= r_brk;
                            r_scan_ext   <= r_ext;
                            r_ext        <= 1'b0;
                            r_brk        <= 1'b0;
                            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                                if (KEYMAP[9*i +: 9] == {r_ext, r_shift}) begin
                                    r_keydown[i] <= ~r_brk;
                                end
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Output ports
    always_comb begin
        KeyDown   = r_keydown;
        ScanValid = r_scan_valid;
        ScanCode  = r_scan_code;
        ScanBreak = r_scan_break;
        ScanExt   = r_scan_ext;
        FrameErr  = r_frame_err;
    end

endmodule
